// File: rtl/sword_anim_addr_gen_pkg.sv
// Shared types and constants for the sword animation address stage and
// the sprite hit-test block that later sprite stages will reuse.
package sword_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SWING = 2'd2
  } anim_state_t;

  // Default geometry and animation timing
  localparam int SPR_W_DEF       = 32;
  localparam int SPR_H_DEF       = 32;
  localparam int N_FRAMES_DEF    = 4;
  localparam int FRAME_TICKS_DEF = 6;

  // Screen coordinates are 10 bits; box origins need a sign bit on top
  localparam int COORD_W = 10;
  localparam int POS_W   = 11;

  // ROM address fields: {dir, frame, dy, dx}
  localparam int DIR_W      = 2;
  localparam int FRAME_W    = 2;
  localparam int DY_W       = 5;
  localparam int DX_W       = 5;
  localparam int ROM_ADDR_W = DIR_W + FRAME_W + DY_W + DX_W;

  typedef struct packed {
    logic [POS_W-1:0] sx;
    logic [POS_W-1:0] sy;
  } origin_t;

  // Sword box top-left corner: one sprite step away from Link, in the
  // facing direction. Result may be negative (two's complement, 11 bits).
  function automatic origin_t box_origin(input dir_t d,
                                         input logic [COORD_W-1:0] lx,
                                         input logic [COORD_W-1:0] ly,
                                         input int w, input int h);
    origin_t o;
    o.sx = {1'b0, lx};
    o.sy = {1'b0, ly};
    case (d)
      UP:      o.sy = o.sy - POS_W'(h);
      DOWN:    o.sy = o.sy + POS_W'(h);
      LEFT:    o.sx = o.sx - POS_W'(w);
      default: o.sx = o.sx + POS_W'(w);
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sword_anim_addr_gen_if.sv
// Pixel/control bus between the video timing + game logic side (master)
// and the sword address stage (slave).
interface sword_anim_addr_gen_if;
  import sword_pkg::*;

  logic                  frame_start;
  logic                  attack;
  logic [DIR_W-1:0]      dir;
  logic [COORD_W-1:0]    link_x;
  logic [COORD_W-1:0]    link_y;
  logic [COORD_W-1:0]    DrawX;
  logic [COORD_W-1:0]    DrawY;
  logic                  blank;
  logic [ROM_ADDR_W-1:0] rom_address;
  logic                  sprite_on;
  logic                  busy;
  logic                  anim_done;

  modport master (
    output frame_start, attack, dir, link_x, link_y, DrawX, DrawY, blank,
    input  rom_address, sprite_on, busy, anim_done
  );

  modport slave (
    input  frame_start, attack, dir, link_x, link_y, DrawX, DrawY, blank,
    output rom_address, sprite_on, busy, anim_done
  );
endinterface

// File: rtl/sword_anim_addr_gen_sprite_box_hit.sv
// Combinational hit test of the current pixel against a sprite box whose
// origin may lie partly off screen. Offsets are only meaningful when
// o_in_box is set.
module sprite_box_hit
  import sword_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int OX_W  = $clog2(SPR_W),
  parameter int OY_W  = $clog2(SPR_H)
) (
  input  logic [COORD_W-1:0] i_draw_x,
  input  logic [COORD_W-1:0] i_draw_y,
  input  logic [POS_W-1:0]   i_sx,
  input  logic [POS_W-1:0]   i_sy,
  output logic               o_in_box,
  output logic [OX_W-1:0]    o_dx,
  output logic [OY_W-1:0]    o_dy
);

  logic [POS_W-1:0] w_dx;
  logic [POS_W-1:0] w_dy;
  logic             w_x_ok;
  logic             w_y_ok;

  // Signed 11-bit difference: a negative result (MSB set) is left of/above
  // the box, so clipping needs no special case and never wraps.
  assign w_dx   = {1'b0, i_draw_x} - i_sx;
  assign w_dy   = {1'b0, i_draw_y} - i_sy;
  assign w_x_ok = !w_dx[POS_W-1] && (w_dx[POS_W-2:0] < (POS_W-1)'(SPR_W));
  assign w_y_ok = !w_dy[POS_W-1] && (w_dy[POS_W-2:0] < (POS_W-1)'(SPR_H));

  assign o_in_box = w_x_ok && w_y_ok;
  assign o_dx     = w_dx[OX_W-1:0];
  assign o_dy     = w_dy[OY_W-1:0];

endmodule

// File: rtl/sword_anim_addr_gen.sv
// Sword swing animation and ROM address stage. Runs the swing FSM, latches
// direction and box origin at swing start, and registers sprite_on so it
// lines up with the synchronous sword ROM output.
module sword_anim_addr_gen
  import sword_pkg::*;
#(
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int N_FRAMES    = N_FRAMES_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  sword_anim_addr_gen_if.slave bus
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  anim_state_t      r_state, w_state_next;
  logic [FW-1:0]    r_frame, w_frame_next;
  logic [TW-1:0]    r_tick, w_tick_next;
  dir_t             r_dir, w_dir_next;
  logic [POS_W-1:0] r_sx, w_sx_next;
  logic [POS_W-1:0] r_sy, w_sy_next;
  logic             r_anim_done, w_anim_done_next;
  logic             r_sprite_on;
  logic             w_latch;
  origin_t          w_origin;
  logic             w_in_box;
  logic [XW-1:0]    w_dx;
  logic [YW-1:0]    w_dy;

  assign w_origin = box_origin(dir_t'(bus.dir), bus.link_x, bus.link_y, SPR_W, SPR_H);

  sprite_box_hit #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .OX_W  (XW),
    .OY_W  (YW)
  ) u_hit (
    .i_draw_x (bus.DrawX),
    .i_draw_y (bus.DrawY),
    .i_sx     (r_sx),
    .i_sy     (r_sy),
    .o_in_box (w_in_box),
    .o_dx     (w_dx),
    .o_dy     (w_dy)
  );

  // Next-state logic: swing FSM, tick/frame counters and swing-start latch
  always_comb begin
    w_state_next     = r_state;
    w_frame_next     = r_frame;
    w_tick_next      = r_tick;
    w_dir_next       = r_dir;
    w_sx_next        = r_sx;
    w_sy_next        = r_sy;
    w_anim_done_next = 1'b0;
    w_latch          = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.attack) begin
          if (bus.frame_start) begin
            w_latch      = 1'b1;
            w_state_next = SWING;
          end else begin
            w_state_next = ARMED;
          end
        end
      end
      ARMED: begin
        if (bus.frame_start) begin
          w_latch      = 1'b1;
          w_state_next = SWING;
        end
      end
      SWING: begin
        if (bus.frame_start) begin
          if (r_tick == TW'(FRAME_TICKS - 1)) begin
            w_tick_next = '0;
            if (r_frame == FW'(N_FRAMES - 1)) begin
              w_state_next     = IDLE;
              w_anim_done_next = 1'b1;
            end else begin
              w_frame_next = r_frame + 1'b1;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Direction and position are frozen for the whole swing so the sword
    // cannot tear if Link moves or turns mid-frame.
    if (w_latch) begin
      w_dir_next   = dir_t'(bus.dir);
      w_sx_next    = w_origin.sx;
      w_sy_next    = w_origin.sy;
      w_frame_next = '0;
      w_tick_next  = '0;
    end
  end

  // State register plus the sprite_on pipeline stage matching ROM latency
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_tick      <= '0;
      r_dir       <= UP;
      r_sx        <= '0;
      r_sy        <= '0;
      r_anim_done <= 1'b0;
      r_sprite_on <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame     <= w_frame_next;
      r_tick      <= w_tick_next;
      r_dir       <= w_dir_next;
      r_sx        <= w_sx_next;
      r_sy        <= w_sy_next;
      r_anim_done <= w_anim_done_next;
      r_sprite_on <= w_in_box & bus.blank & (r_state == SWING);
    end
  end

  assign bus.rom_address = {r_dir, r_frame, w_dy, w_dx};
  assign bus.sprite_on   = r_sprite_on;
  assign bus.busy        = (r_state != IDLE);
  assign bus.anim_done   = r_anim_done;

endmodule

// File: tb/tb_sword_anim_addr_gen.sv
// Directed bench for the sword address stage: expected pixel results are
// queued when a pixel is driven and checked when sprite_on/ROM q arrive.
module tb_sword_anim_addr_gen;

  logic vga_clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;

  typedef struct packed {
    logic        on;
    logic [13:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] rom_q;

  sword_anim_addr_gen_if bus_if ();

  sword_anim_addr_gen dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 vga_clk = ~vga_clk;

  // Bench sword ROM with fixed, address-dependent contents
  function automatic logic [15:0] rom_fn(input logic [13:0] a);
    return {a[6:0], a[13:5]} ^ 16'h5A3C;
  endfunction

  // Synchronous ROM model, 1-cycle read latency
  always @(posedge vga_clk) rom_q <= rom_fn(bus_if.rom_address);

  function automatic logic [13:0] mk_addr(input int d, input int f, input int dy, input int dx);
    return {2'(d), 2'(f), 5'(dy), 5'(dx)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_fs();
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.frame_start = 1'b0;
  endtask

  task automatic pixel(input string tag, input int x, input int y, input logic blk,
                       input logic on, input logic [13:0] addr);
    exp_t e;
    bus_if.DrawX = 10'(x);
    bus_if.DrawY = 10'(y);
    bus_if.blank = blk;
    e.on   = on;
    e.addr = addr;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    $display("pixel %s (%0d,%0d) blank=%0b sprite_on=%0b addr=%h q=%h",
             tag, x, y, blk, bus_if.sprite_on, bus_if.rom_address, rom_q);
    chk({tag, ".on"}, 32'(bus_if.sprite_on), 32'(e.on));
    if (e.on) begin
      chk({tag, ".addr"}, 32'(bus_if.rom_address), 32'(e.addr));
      chk({tag, ".q"}, 32'(rom_q), 32'(rom_fn(e.addr)));
    end
  endtask

  // 24 frame_start pulses after swing entry: frame steps at 6/12/18,
  // anim_done and busy falling on pulse 24
  task automatic swing_timing(input string tag);
    for (int k = 1; k <= 24; k++) begin
      tick();
      pulse_fs();
      chk({tag, ".done"}, 32'(bus_if.anim_done), 32'(k == 24));
      chk({tag, ".busy"}, 32'(bus_if.busy), 32'(k != 24));
      if (k < 24) chk({tag, ".frame"}, 32'(bus_if.rom_address[11:10]), 32'(k / 6));
    end
    $display("swing %s complete", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n            = 1'b0;
    bus_if.frame_start = 1'b0;
    bus_if.attack      = 1'b0;
    bus_if.dir         = 2'd0;
    bus_if.link_x      = '0;
    bus_if.link_y      = '0;
    bus_if.DrawX       = '0;
    bus_if.DrawY       = '0;
    bus_if.blank       = 1'b0;
    repeat (3) tick();
    chk("rst.busy", 32'(bus_if.busy), 32'd0);
    chk("rst.sprite_on", 32'(bus_if.sprite_on), 32'd0);
    chk("rst.done", 32'(bus_if.anim_done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Right swing, attack held through the whole swing (must be ignored)
    bus_if.link_x = 10'd100;
    bus_if.link_y = 10'd200;
    bus_if.dir    = 2'd3;
    bus_if.attack = 1'b1;
    tick();
    chk("armed.busy", 32'(bus_if.busy), 32'd1);
    pulse_fs();
    // Later changes must not affect the latched swing
    bus_if.dir    = 2'd0;
    bus_if.link_x = 10'd500;
    bus_if.link_y = 10'd400;
    pixel("right.origin", 132, 200, 1'b1, 1'b1, 14'h3000);
    pixel("right.far", 164, 200, 1'b1, 1'b0, 14'h0);
    pixel("right.corner", 163, 231, 1'b1, 1'b1, mk_addr(3, 0, 31, 31));
    pixel("right.blank", 140, 205, 1'b0, 1'b0, 14'h0);
    pixel("right.left_of", 131, 210, 1'b1, 1'b0, 14'h0);
    swing_timing("right");

    // Attack still high: re-arms on the next cycle
    bus_if.link_x = 10'd10;
    bus_if.link_y = 10'd50;
    bus_if.dir    = 2'd2;
    tick();
    chk("rearm.busy", 32'(bus_if.busy), 32'd1);
    chk("rearm.done", 32'(bus_if.anim_done), 32'd0);
    bus_if.attack = 1'b0;
    pulse_fs();

    // Left swing with box clipped at the left screen edge (sx = -22)
    pixel("left.x0", 0, 50, 1'b1, 1'b1, mk_addr(2, 0, 0, 22));
    pixel("left.x10", 10, 50, 1'b1, 1'b0, 14'h0);
    pixel("left.nowrap", 630, 50, 1'b1, 1'b0, 14'h0);
    pixel("left.bottom", 0, 81, 1'b1, 1'b1, mk_addr(2, 0, 31, 22));
    pixel("left.below", 0, 82, 1'b1, 1'b0, 14'h0);
    for (int k = 0; k < 12; k++) begin
      tick();
      pulse_fs();
    end
    chk("left.frame2", 32'(bus_if.rom_address[11:10]), 32'd2);
    chk("left.busy", 32'(bus_if.busy), 32'd1);

    // Reset mid-swing: aborted, no anim_done
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst.done", 32'(bus_if.anim_done), 32'd0);
    end
    reset_n = 1'b1;
    chk("midrst.busy", 32'(bus_if.busy), 32'd0);
    chk("midrst.sprite_on", 32'(bus_if.sprite_on), 32'd0);
    chk("midrst.frame", 32'(bus_if.rom_address[11:10]), 32'd0);
    tick();
    chk("postrst.done", 32'(bus_if.anim_done), 32'd0);
    chk("postrst.busy", 32'(bus_if.busy), 32'd0);

    // Attack and frame_start together in IDLE: straight into SWING
    bus_if.dir         = 2'd1;
    bus_if.link_x      = 10'd300;
    bus_if.link_y      = 10'd100;
    bus_if.attack      = 1'b1;
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.attack      = 1'b0;
    bus_if.frame_start = 1'b0;
    chk("direct.busy", 32'(bus_if.busy), 32'd1);
    pixel("down.origin", 300, 132, 1'b1, 1'b1, 14'h1000);
    pixel("down.corner", 331, 163, 1'b1, 1'b1, mk_addr(1, 0, 31, 31));
    pixel("down.left_of", 299, 132, 1'b1, 1'b0, 14'h0);
    pixel("down.below", 300, 164, 1'b1, 1'b0, 14'h0);
    pixel("down.blank", 310, 140, 1'b0, 1'b0, 14'h0);
    // A single attack pulse mid-swing must not extend or restart it
    bus_if.attack = 1'b1;
    tick();
    bus_if.attack = 1'b0;
    swing_timing("down");
    tick();
    chk("end.done_low", 32'(bus_if.anim_done), 32'd0);
    chk("end.busy", 32'(bus_if.busy), 32'd0);
    pixel("idle.inbox", 300, 132, 1'b1, 1'b0, 14'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
